// File: rtl/elevator_pkg.sv
// Shared definitions for the elevator request panel and controller:
// button bit map, floor width and travel direction encoding.
package elevator_pkg;
    localparam int NUM_BTN = 7;
    localparam int FLOOR_W = 2;

    localparam int BTN_CALL_UP_0  = 0;
    localparam int BTN_CALL_UP_1  = 1;
    localparam int BTN_CALL_DN_1  = 2;
    localparam int BTN_CALL_DN_2  = 3;
    localparam int BTN_SEL_0      = 4;
    localparam int BTN_SEL_1      = 5;
    localparam int BTN_SEL_2      = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } dir_t;
endpackage

// File: rtl/elevator_request_panel_if.sv
// Panel-side bundle: raw buttons and controller status in, request strobes
// and lamps out.
interface elevator_request_panel_if;
    import elevator_pkg::*;

    logic [NUM_BTN-1:0] btn_raw;
    logic [FLOOR_W-1:0] current_floor;
    logic               door_open;
    logic               moving_up;
    logic               moving_down;
    logic [NUM_BTN-1:0] req_pulse;
    logic [NUM_BTN-1:0] lamp;

    modport master (
        output btn_raw, current_floor, door_open, moving_up, moving_down,
        input  req_pulse, lamp
    );

    modport slave (
        input  btn_raw, current_floor, door_open, moving_up, moving_down,
        output req_pulse, lamp
    );
endinterface

// File: rtl/elevator_btn_debounce.sv
// One pushbutton: 2-flop synchroniser, run-length debouncer and a
// one-cycle press strobe on each accepted rising level.
module elevator_btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic press
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             deb_d, deb_q, deb_prev_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;

    // A mismatch run of DEBOUNCE_CYCLES flips deb; any agreeing cycle restarts the run.
    always_comb begin
        deb_d = deb_q;
        cnt_d = '0;
        if (sync2_q != deb_q) begin
            if (cnt_q == CNT_LAST) deb_d = ~deb_q;
            else                   cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            deb_q      <= 1'b0;
            deb_prev_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            sync1_q    <= din;
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            cnt_q      <= cnt_d;
        end
    end

    assign press = deb_q & ~deb_prev_q;
endmodule

// File: rtl/elevator_request_panel.sv
// Request panel top: debounced presses latch lamps and strobe requests to
// the controller; lamps clear when the car serves the matching request.
module elevator_request_panel
    import elevator_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic                     clk,
    input  logic                     rst,
    elevator_request_panel_if.slave  bus
);
    logic [NUM_BTN-1:0] press;
    logic [NUM_BTN-1:0] clr;
    logic [NUM_BTN-1:0] lamp_d, lamp_q;
    logic [NUM_BTN-1:0] pulse_d, pulse_q;
    dir_t               last_dir_d, last_dir_q;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        elevator_btn_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_deb (
            .clk   (clk),
            .rst   (rst),
            .din   (bus.btn_raw[i]),
            .press (press[i])
        );
    end

    // Both motion flags high is a controller fault; keep the last good direction.
    always_comb begin
        last_dir_d = last_dir_q;
        if (bus.moving_up && !bus.moving_down)      last_dir_d = UP;
        else if (bus.moving_down && !bus.moving_up) last_dir_d = DOWN;
    end

    // At floor 1 the hall call served depends on the direction the car was travelling.
    always_comb begin
        clr = '0;
        if (bus.door_open) begin
            case (bus.current_floor)
                2'd0: begin
                    clr[BTN_CALL_UP_0] = 1'b1;
                    clr[BTN_SEL_0]     = 1'b1;
                end
                2'd1: begin
                    clr[BTN_SEL_1]     = 1'b1;
                    clr[BTN_CALL_UP_1] = (last_dir_q != DOWN);
                    clr[BTN_CALL_DN_1] = (last_dir_q != UP);
                end
                2'd2: begin
                    clr[BTN_CALL_DN_2] = 1'b1;
                    clr[BTN_SEL_2]     = 1'b1;
                end
                default: clr = '0;
            endcase
        end
    end

    always_comb begin
        lamp_d  = (lamp_q | press) & ~clr;
        pulse_d = press & ~lamp_q & ~clr;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lamp_q     <= '0;
            pulse_q    <= '0;
            last_dir_q <= IDLE;
        end else begin
            lamp_q     <= lamp_d;
            pulse_q    <= pulse_d;
            last_dir_q <= last_dir_d;
        end
    end

    assign bus.lamp      = lamp_q;
    assign bus.req_pulse = pulse_q;
endmodule

// File: tb/tb_elevator_request_panel.sv
// Bench for elevator_request_panel with DEBOUNCE_CYCLES=4: directed scenarios
// plus random button/status traffic, checked against a behavioural model.
module tb_elevator_request_panel;
    localparam int DC = 4;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    elevator_request_panel_if bus();

    elevator_request_panel #(.DEBOUNCE_CYCLES(DC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Behavioural model: raw is seen two edges late, a level is accepted after
    // DC consecutive disagreeing observations, and the request is acted on at
    // the edge after acceptance.
    logic [6:0] m_s1, m_s2, m_deb, m_pend, m_lamp, m_pulse;
    int         m_run [7];
    int         m_dir;          // 0 idle, 1 up, 2 down
    bit         m_started = 0;

    always @(posedge clk) begin
        logic [6:0] clr;
        logic [6:0] new_pend;
        m_started = 1;
        if (rst) begin
            m_s1 = 0; m_s2 = 0; m_deb = 0; m_pend = 0; m_lamp = 0; m_pulse = 0;
            m_dir = 0;
            for (int i = 0; i < 7; i++) m_run[i] = 0;
        end else begin
            clr = 0;
            if (bus.door_open) begin
                if (bus.current_floor == 0) clr = 7'b001_0001;
                if (bus.current_floor == 1) begin
                    clr[5] = 1;
                    clr[1] = (m_dir != 2);
                    clr[2] = (m_dir != 1);
                end
                if (bus.current_floor == 2) clr = 7'b100_1000;
            end
            for (int i = 0; i < 7; i++) begin
                m_pulse[i] = 0;
                if (clr[i]) m_lamp[i] = 0;
                else if (m_pend[i] && !m_lamp[i]) begin
                    m_lamp[i]  = 1;
                    m_pulse[i] = 1;
                end
            end
            new_pend = 0;
            for (int i = 0; i < 7; i++) begin
                if (m_s2[i] != m_deb[i]) m_run[i]++;
                else m_run[i] = 0;
                if (m_run[i] == DC) begin
                    m_deb[i]    = ~m_deb[i];
                    m_run[i]    = 0;
                    new_pend[i] = m_deb[i];
                end
            end
            m_pend = new_pend;
            m_s2 = m_s1;
            m_s1 = bus.btn_raw;
            if (bus.moving_up && !bus.moving_down) m_dir = 1;
            else if (bus.moving_down && !bus.moving_up) m_dir = 2;
        end
    end

    task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_started) begin
            check("model_lamp",  bus.lamp,      m_lamp);
            check("model_pulse", bus.req_pulse, m_pulse);
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    int cnt4;

    initial begin
        rst = 1;
        bus.btn_raw = 7'h7F;
        bus.current_floor = 0;
        bus.door_open = 0;
        bus.moving_up = 0;
        bus.moving_down = 0;

        // reset with all buttons held
        step(3);
        check("rst_lamp",  bus.lamp,      7'h00);
        check("rst_pulse", bus.req_pulse, 7'h00);
        rst = 0;
        step(6);
        check("rst_no_early", bus.req_pulse, 7'h00);
        step(1);
        check("rst_pulse_all", bus.req_pulse, 7'h7F);
        check("rst_lamp_all",  bus.lamp,      7'h7F);
        step(1);
        check("rst_pulse_once", bus.req_pulse, 7'h00);
        bus.btn_raw = 0;
        step(10);

        // serve every floor with direction idle
        bus.door_open = 1;
        bus.current_floor = 0; step(1);
        bus.current_floor = 1; step(1);
        bus.current_floor = 2; step(1);
        bus.door_open = 0; bus.current_floor = 0; step(1);
        check("clear_all", bus.lamp, 7'h00);

        // clean press on bit 6, then a short glitch on bit 5
        bus.btn_raw = 7'h40;
        step(6);
        check("b6_no_early", bus.req_pulse, 7'h00);
        step(1);
        check("b6_pulse", bus.req_pulse, 7'h40);
        step(3);
        bus.btn_raw = 0;
        check("b6_lamp", bus.lamp, 7'h40);
        bus.btn_raw = 7'h20; step(3);
        bus.btn_raw = 0;     step(12);
        check("glitch_b5", bus.lamp, 7'h40);

        // service clear at floor 2, and no clear for invalid floor 3
        bus.btn_raw = 7'h09; step(10);
        bus.btn_raw = 0;     step(10);
        check("svc_pre", bus.lamp, 7'h49);
        bus.door_open = 1; bus.current_floor = 3; step(1);
        check("svc_floor3", bus.lamp, 7'h49);
        bus.current_floor = 2; step(1);
        check("svc_floor2", bus.lamp, 7'h01);
        bus.door_open = 0; bus.current_floor = 0;

        // direction-qualified clear at floor 1
        bus.moving_up = 1; step(1); bus.moving_up = 0;
        bus.btn_raw = 7'h26; step(10);
        bus.btn_raw = 0;     step(10);
        check("dir_pre", bus.lamp, 7'h27);
        bus.current_floor = 1; bus.door_open = 1; step(1);
        check("dir_up_f1", bus.lamp, 7'h05);
        bus.door_open = 0;
        bus.moving_down = 1; step(1); bus.moving_down = 0;
        bus.door_open = 1; step(1);
        check("dir_dn_f1", bus.lamp, 7'h01);
        bus.current_floor = 0; step(1);
        bus.door_open = 0;
        check("dir_done", bus.lamp, 7'h00);

        // duplicate press is suppressed
        bus.btn_raw = 7'h10; step(10);
        bus.btn_raw = 0;     step(10);
        bus.btn_raw = 7'h10; cnt4 = 0;
        for (int k = 0; k < 12; k++) begin step(1); cnt4 += int'(bus.req_pulse[4]); end
        bus.btn_raw = 0; step(10);
        total++;
        if (cnt4 != 0) begin bad++; $display("FAIL dup_pulses: got %0d expected 0", cnt4); end
        check("dup_lamp", bus.lamp, 7'h10);

        // press accepted while its own floor is being served
        bus.door_open = 1; bus.current_floor = 0; step(1);
        check("conf_clear", bus.lamp, 7'h00);
        bus.btn_raw = 7'h10; cnt4 = 0;
        for (int k = 0; k < 12; k++) begin step(1); cnt4 += int'(bus.req_pulse[4]); end
        total++;
        if (cnt4 != 0) begin bad++; $display("FAIL conf_pulses: got %0d expected 0", cnt4); end
        check("conf_lamp", bus.lamp, 7'h00);
        bus.btn_raw = 0; step(10);
        bus.door_open = 0;

        // reset mid-debounce with the button held throughout
        bus.btn_raw = 7'h01; step(2);
        rst = 1; step(2);
        rst = 0; step(6);
        check("rmid_no_early", bus.req_pulse, 7'h00);
        step(1);
        check("rmid_pulse", bus.req_pulse, 7'h01);
        bus.btn_raw = 0; step(10);

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < 7; b++)
                if ($urandom_range(0, 9) == 0) bus.btn_raw[b] = ~bus.btn_raw[b];
            bus.door_open     = ($urandom_range(0, 5) == 0);
            bus.current_floor = 2'($urandom_range(0, 3));
            bus.moving_up     = ($urandom_range(0, 3) == 0);
            bus.moving_down   = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 499) == 0) rst = 1; else rst = 0;
            step(1);
        end
        rst = 0;
        step(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
